// File: rtl/uart_buffered_unit.sv
// FIFO-buffered full-duplex 8N1/8N2 UART behind the controller's single-request
// uart_go/rors/uart_done handshake; RX and TX each own an independent FIFO.
`timescale 1ns/1ps
module uart_buffered_unit #(
    parameter int CLKS_PER_BIT = 868,
    parameter int RX_DEPTH     = 16,
    parameter int TX_DEPTH     = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          uart_go,
    input  logic                          rors,
    input  logic [7:0]                    txdata,
    output logic [7:0]                    rxdata,
    output logic                          uart_done,
    output logic [$clog2(RX_DEPTH+1)-1:0] rx_count,
    output logic [$clog2(TX_DEPTH+1)-1:0] tx_count,
    input  logic                          err_clr,
    output logic                          rx_overrun,
    output logic                          rx_frame_err,
    output logic                          txd,
    input  logic                          rxd
);

    localparam int RCW = $clog2(RX_DEPTH + 1);
    localparam int TCW = $clog2(TX_DEPTH + 1);
    localparam int RPW = $clog2(RX_DEPTH);
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int CW  = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RCW-1:0] RX_FULL   = RCW'(RX_DEPTH);
    localparam logic [TCW-1:0] TX_FULL   = TCW'(TX_DEPTH);
    localparam logic           STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Request path
    logic       pending;
    logic       pend_rors;
    logic [7:0] pend_data;
    logic       done_stage;
    logic       req_active;
    logic       req_rors;
    logic [7:0] req_data;
    logic       core_pop;
    logic       core_push;

    // RX side
    logic           rxd_meta;
    logic           rxd_sync;
    logic           rxd_prev;
    rx_state_t      rx_state;
    logic [CW-1:0]  rx_cnt;
    logic [2:0]     rx_bit;
    logic [7:0]     rx_shift;
    logic           rx_valid;
    logic           rx_stop_ok;
    logic           rx_push;
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RPW-1:0] rx_wr_ptr;
    logic [RPW-1:0] rx_rd_ptr;

    // TX side
    tx_state_t      tx_state;
    logic [CW-1:0]  tx_cnt;
    logic [2:0]     tx_bit;
    logic           tx_stop_idx;
    logic [7:0]     tx_shift;
    logic           tx_bit_end;
    logic           tx_pop;
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TPW-1:0] tx_wr_ptr;
    logic [TPW-1:0] tx_rd_ptr;

    // A pending request takes priority over a new strobe, which is ignored.
    always_comb begin
        req_active = pending | uart_go;
        req_rors   = pending ? pend_rors : rors;
        req_data   = pending ? pend_data : txdata;
        core_pop   = req_active & ~req_rors & (rx_count != '0);
        core_push  = req_active &  req_rors & (tx_count != TX_FULL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending    <= 1'b0;
            pend_rors  <= 1'b0;
            pend_data  <= 8'h00;
            done_stage <= 1'b0;
            uart_done  <= 1'b0;
            rxdata     <= 8'h00;
        end else begin
            if (!pending && uart_go) begin
                pend_rors <= rors;
                pend_data <= txdata;
            end
            pending    <= req_active & ~(core_pop | core_push);
            done_stage <= core_pop | core_push;
            uart_done  <= done_stage;
            if (core_pop) begin
                rxdata <= rx_mem[rx_rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // The half-bit start wait re-centres sampling on bit midpoints, absorbing the sync delay.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_shift   <= 8'h00;
            rx_valid   <= 1'b0;
            rx_stop_ok <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rxd_prev && !rxd_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= 3'd0;
                        rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rxd_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_valid   <= 1'b1;
                        rx_stop_ok <= rxd_sync;
                        rx_state   <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_push = rx_valid & rx_stop_ok & (rx_count != RX_FULL);

    // A new error event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_count     <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RPW'(1);
            end
            if (core_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RPW'(1);
            end
            if (rx_push && !core_pop) begin
                rx_count <= rx_count + RCW'(1);
            end else if (!rx_push && core_pop) begin
                rx_count <= rx_count - RCW'(1);
            end
            if (rx_valid && rx_stop_ok && rx_count == RX_FULL) begin
                rx_overrun <= 1'b1;
            end else if (err_clr) begin
                rx_overrun <= 1'b0;
            end
            if (rx_valid && !rx_stop_ok) begin
                rx_frame_err <= 1'b1;
            end else if (err_clr) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_shift;
        end
    end

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    assign tx_pop     = (tx_count != '0) &
                        ((tx_state == TX_IDLE) |
                         ((tx_state == TX_STOP) & tx_bit_end & (tx_stop_idx == STOP_LAST)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (core_push) begin
                tx_wr_ptr <= tx_wr_ptr + TPW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TPW'(1);
            end
            if (core_push && !tx_pop) begin
                tx_count <= tx_count + TCW'(1);
            end else if (!core_push && tx_pop) begin
                tx_count <= tx_count - TCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (core_push) begin
            tx_mem[tx_wr_ptr] <= req_data;
        end
    end

    // Leaving the last stop bit with data queued goes straight into the next start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_bit      <= 3'd0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= 8'h00;
            txd         <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    txd <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= tx_mem[tx_rd_ptr];
                        txd      <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_bit   <= 3'd0;
                        txd      <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            txd         <= 1'b1;
                            tx_stop_idx <= 1'b0;
                            tx_state    <= TX_STOP;
                        end else begin
                            txd      <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_stop_idx != STOP_LAST) begin
                            tx_stop_idx <= 1'b1;
                        end else if (tx_pop) begin
                            tx_shift <= tx_mem[tx_rd_ptr];
                            txd      <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule
